// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit-sharing controller.
package uart_ctrl_pkg;

    // Controller FSM states; the encodings are fixed by the existing codebase.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_WAIT_DONE  = 2'd2,
        ST_CONFIG     = 2'd3
    } state_t;

    // Largest supported number of requesters.
    localparam int unsigned NUM_REQ_MAX = 8;

    // Default number of cycles to wait for the core to report busy.
    localparam int unsigned START_TIMEOUT_DEFAULT = 3;

    // Index following idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot priority pick, searching upward from a start index
// and wrapping around the request vector.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]               req,
    input  logic [$clog2(N)-1:0]       start,
    output logic [N-1:0]               grant,
    output logic [$clog2(N)-1:0]       grant_idx,
    output logic                       found
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] idx;

    // First requester at or after start (modulo N) wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(start) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters with
// round-robin arbitration and per-packet locking, and sequences clock
// divider updates so they reach the core only while it is fully idle.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_byte,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   cfg_set,
    input  logic [31:0]            cfg_clock_div,
    output logic                   cfg_pending,
    output logic                   cfg_done,
    output logic                   tx_error,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_is_transmitting,
    input  logic                   uart_is_receiving,
    output logic                   uart_set_clock_div,
    output logic [31:0]            uart_user_clock_div
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    state_t               state_q, state_d;

    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        last_owner_q;
    logic                 lock_q;
    logic [7:0]           byte_q;
    logic                 last_q;
    logic [CW-1:0]        timer_q;
    logic                 pending_q;
    logic [31:0]          div_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 transmit_q;
    logic                 error_q;

    logic [NUM_REQ-1:0]   owner_onehot;
    logic [NUM_REQ-1:0]   arb_req;
    logic [IW-1:0]        arb_start;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_found;

    logic                 grant_fire;
    logic                 timeout_fire;
    logic                 done_fire;
    logic                 config_fire;

    // While a packet is locked only its owner may be picked.
    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
        if (lock_q) begin
            arb_req   = req_valid & owner_onehot;
            arb_start = owner_q;
        end else begin
            arb_req   = req_valid;
            arb_start = IW'(wrap_inc(32'(last_owner_q), NUM_REQ));
        end
    end

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req       (arb_req),
        .start     (arb_start),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .found     (arb_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; config update wins over new grants when unlocked.
    always_comb begin
        state_d      = state_q;
        grant_fire   = 1'b0;
        timeout_fire = 1'b0;
        done_fire    = 1'b0;
        config_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!lock_q && pending_q && !uart_is_transmitting && !uart_is_receiving) begin
                    state_d = ST_CONFIG;
                end else if (arb_found) begin
                    grant_fire = 1'b1;
                    state_d    = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == CW'(START_TIMEOUT - 1)) begin
                    timeout_fire = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    done_fire = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_CONFIG: begin
                config_fire = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant bookkeeping: latch the winner's byte and emit the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= '0;
            transmit_q <= 1'b0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            owner_q    <= '0;
        end else begin
            ready_q    <= '0;
            transmit_q <= 1'b0;
            if (grant_fire) begin
                ready_q    <= arb_grant;
                transmit_q <= 1'b1;
                byte_q     <= req_byte[{arb_idx, 3'b000} +: 8];
                last_q     <= req_last[arb_idx];
                owner_q    <= arb_idx;
            end
        end
    end

    // Start timeout: counts idle-core cycles spent in ST_WAIT_START.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= timeout_fire;
            if (grant_fire) begin
                timer_q <= '0;
            end else if (state_q == ST_WAIT_START && !uart_is_transmitting) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Packet lock and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            last_owner_q <= IW'(NUM_REQ - 1);
        end else begin
            if (grant_fire && !req_last[arb_idx]) begin
                lock_q <= 1'b1;
            end
            if (timeout_fire) begin
                lock_q <= 1'b0;
            end
            if (done_fire) begin
                last_owner_q <= owner_q;
                if (last_q) begin
                    lock_q <= 1'b0;
                end
            end
        end
    end

    // Divider latch; a new cfg_set during ST_CONFIG stays pending for another pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            div_q     <= '0;
        end else begin
            if (cfg_set) begin
                div_q     <= cfg_clock_div;
                pending_q <= 1'b1;
            end else if (config_fire) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign req_ready           = ready_q;
    assign uart_transmit       = transmit_q;
    assign uart_tx_byte        = transmit_q ? byte_q : '0;
    assign tx_error            = error_q;
    assign cfg_pending         = pending_q;
    assign cfg_done            = config_fire;
    assign uart_set_clock_div  = config_fire;
    assign uart_user_clock_div = div_q;

endmodule
